// File: rtl/pixel_distributor_if.sv
// Engine-side bus of the pixel distributor: shared pixel coordinates plus the
// per-engine ready/valid handshake vectors.
interface pixel_distributor_if #(
   parameter int NUM_ENGINES      = 4,
   parameter int PIXEL_DATA_WIDTH = 10
);
   logic [NUM_ENGINES-1:0]      engine_ready;
   logic [NUM_ENGINES-1:0]      pixel_valid;
   logic [PIXEL_DATA_WIDTH-1:0] x0_;
   logic [PIXEL_DATA_WIDTH-1:0] y0_;

   modport master (
      input  engine_ready,
      output pixel_valid,
      output x0_,
      output y0_
   );

   modport slave (
      output engine_ready,
      input  pixel_valid,
      input  x0_,
      input  y0_
   );
endinterface

// File: rtl/pixel_distributor.sv
// Raster-scans the screen and hands one pixel coordinate per transfer to the
// engine array, granting ready engines in round-robin order.
module pixel_distributor #(
   parameter int NUM_ENGINES      = 4,
   parameter int PIXEL_DATA_WIDTH = 10,
   parameter int SCREEN_WIDTH     = 640,
   parameter int SCREEN_HEIGHT    = 480
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   pixel_distributor_if.master    eng,
   output logic                   busy,
   output logic                   frame_done
);

   localparam int PTR_W = (NUM_ENGINES > 1) ? $clog2(NUM_ENGINES) : 1;
   localparam logic [PIXEL_DATA_WIDTH-1:0] X_LAST = PIXEL_DATA_WIDTH'(SCREEN_WIDTH - 1);
   localparam logic [PIXEL_DATA_WIDTH-1:0] Y_LAST = PIXEL_DATA_WIDTH'(SCREEN_HEIGHT - 1);
   localparam logic [PTR_W-1:0]            PTR_LAST = PTR_W'(NUM_ENGINES - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_DONE  = 2'd2
   } state_e;

   state_e                      state_q, state_d;
   logic [PIXEL_DATA_WIDTH-1:0] x_q, x_d;
   logic [PIXEL_DATA_WIDTH-1:0] y_q, y_d;
   logic [PTR_W-1:0]            rr_q, rr_d;
   logic                        busy_q, busy_d;
   logic                        done_q, done_d;

   int                          cand_s;
   logic [PTR_W-1:0]            cand_idx_s;
   logic                        grant_found_s;
   logic [PTR_W-1:0]            grant_idx_s;
   logic [NUM_ENGINES-1:0]      grant_s;
   logic                        transfer_s;

   // Round-robin search: first ready engine at or after rr_q, wrapping.
   always_comb begin
      cand_s        = 0;
      cand_idx_s    = '0;
      grant_found_s = 1'b0;
      grant_idx_s   = '0;
      for (int k = 0; k < NUM_ENGINES; k++) begin
         cand_s = int'(rr_q) + k;
         if (cand_s >= NUM_ENGINES) begin
            cand_s = cand_s - NUM_ENGINES;
         end else begin
            cand_s = cand_s;
         end
         cand_idx_s = PTR_W'(cand_s);
         if (!grant_found_s && eng.engine_ready[cand_idx_s]) begin
            grant_found_s = 1'b1;
            grant_idx_s   = cand_idx_s;
         end else begin
            grant_found_s = grant_found_s;
         end
      end
   end

   // One-hot grant, only while issuing; any grant is a transfer.
   always_comb begin
      grant_s = '0;
      if ((state_q == ST_ISSUE) && grant_found_s) begin
         grant_s[grant_idx_s] = 1'b1;
      end else begin
         grant_s = '0;
      end
      transfer_s = (grant_s != '0);
   end

   // Next-state, raster counters, round-robin pointer and decoded status.
   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      rr_d    = rr_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_ISSUE;
               x_d     = '0;
               y_d     = '0;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_ISSUE: begin
            if (transfer_s) begin
               rr_d = (grant_idx_s == PTR_LAST) ? '0 : grant_idx_s + PTR_W'(1);
               // Final pixel: coordinates freeze until the next start.
               if ((x_q == X_LAST) && (y_q == Y_LAST)) begin
                  state_d = ST_DONE;
               end else if (x_q == X_LAST) begin
                  x_d = '0;
                  y_d = y_q + PIXEL_DATA_WIDTH'(1);
               end else begin
                  x_d = x_q + PIXEL_DATA_WIDTH'(1);
               end
            end else begin
               state_d = ST_ISSUE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      busy_d = (state_d != ST_IDLE);
      done_d = (state_d == ST_DONE);
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         x_q     <= '0;
         y_q     <= '0;
         rr_q    <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         y_q     <= y_d;
         rr_q    <= rr_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign eng.pixel_valid = grant_s;
   assign eng.x0_         = x_q;
   assign eng.y0_         = y_q;
   assign busy            = busy_q;
   assign frame_done      = done_q;

endmodule

// File: tb/tb_pixel_distributor.sv
// Checks pixel_distributor against a pixel-count / phase reference model under
// directed and randomized ready/start/reset stimulus.
module tb_pixel_distributor;

   localparam int N  = 4;
   localparam int PW = 10;
   localparam int W  = 8;
   localparam int H  = 4;

   logic clk = 1'b0;
   logic reset;
   logic start;
   logic busy;
   logic frame_done;

   int checks = 0;
   int errors = 0;

   // Model: phase 0=idle 1=issuing 2=done; count = pixels transferred this frame.
   int phase = 0;
   int count = 0;
   int rr    = 0;
   int exp_gidx;
   logic [N-1:0] exp_pv;

   always #5 clk = ~clk;

   pixel_distributor_if #(.NUM_ENGINES(N), .PIXEL_DATA_WIDTH(PW)) eng_if ();

   pixel_distributor #(
      .NUM_ENGINES(N), .PIXEL_DATA_WIDTH(PW), .SCREEN_WIDTH(W), .SCREEN_HEIGHT(H)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .eng(eng_if),
      .busy(busy), .frame_done(frame_done)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // One clock: drive inputs, compare at negedge, advance the model at posedge.
   task automatic step(input logic rst_v, input logic st, input logic [N-1:0] rdy);
      int ex, ey;
      reset = rst_v;
      start = st;
      eng_if.engine_ready = rdy;
      @(negedge clk);
      exp_pv   = '0;
      exp_gidx = -1;
      if (phase == 1) begin
         for (int k = 0; k < N; k++) begin
            if (exp_gidx < 0 && rdy[(rr + k) % N]) exp_gidx = (rr + k) % N;
         end
         if (exp_gidx >= 0) exp_pv = N'(1) << exp_gidx;
      end
      if (count >= W * H) begin
         ex = W - 1; ey = H - 1;
      end else begin
         ex = count % W; ey = count / W;
      end
      check("pixel_valid", 32'(eng_if.pixel_valid), 32'(exp_pv));
      check("x0_", 32'(eng_if.x0_), 32'(ex));
      check("y0_", 32'(eng_if.y0_), 32'(ey));
      check("busy", 32'(busy), 32'(phase != 0));
      check("frame_done", 32'(frame_done), 32'(phase == 2));
      @(posedge clk);
      if (!rst_v) begin
         phase = 0; count = 0; rr = 0;
      end else if (phase == 0) begin
         if (st) begin phase = 1; count = 0; end
      end else if (phase == 1) begin
         if (exp_gidx >= 0) begin
            rr = (exp_gidx + 1) % N;
            count++;
            if (count == W * H) phase = 2;
         end
      end else begin
         phase = 0;
      end
      #1;
   endtask

   task automatic run_until_idle(input logic st, input logic [N-1:0] rdy, input int budget);
      int n = 0;
      while (phase != 0 && n < budget) begin
         step(1'b1, st, rdy);
         n++;
      end
      check("idle_timeout", 32'(phase), 32'd0);
   endtask

   task automatic run_until_count(input int target, input logic [N-1:0] rdy);
      int n = 0;
      while (count != target && n < 200) begin
         step(1'b1, 1'b0, rdy);
         n++;
      end
      check("count_timeout", 32'(count), 32'(target));
   endtask

   initial begin
      reset = 1'b0;
      start = 1'b1;
      eng_if.engine_ready = '1;
      @(posedge clk);
      #1;

      // Reset held with start and all engines ready
      step(1'b0, 1'b1, '1);
      step(1'b0, 1'b1, '1);

      // Full frame, all ready
      step(1'b1, 1'b1, '1);
      run_until_idle(1'b0, '1, 100);

      // Round-robin with engines 0 and 2 ready
      step(1'b1, 1'b1, 4'b0101);
      run_until_idle(1'b0, 4'b0101, 100);

      // Backpressure at (5,1), then start held high through the rest of the frame
      step(1'b1, 1'b1, '1);
      run_until_count(W + 5, '1);
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0, '0);
      run_until_idle(1'b1, '1, 100);

      // Reset mid-frame at (3,2), then a clean rescan
      step(1'b1, 1'b1, '1);
      run_until_count(2 * W + 3, '1);
      step(1'b0, 1'b0, '1);
      step(1'b1, 1'b0, '1);
      step(1'b1, 1'b1, 4'b1000);
      run_until_idle(1'b0, '1, 100);

      // Randomized ready/start with occasional reset
      for (int f = 0; f < 8; f++) begin
         int n = 0;
         step(1'b1, 1'b1, N'($urandom));
         while (phase != 0 && n < 400) begin
            step(($urandom_range(0, 149) != 0), N'($urandom_range(0, 1)) != '0, N'($urandom));
            n++;
         end
         check("rand_idle", 32'(phase), 32'd0);
         step(1'b1, 1'b0, N'($urandom));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
